// File: rtl/frame_sequencer.sv
// Per-frame GPU controller: paces buffer switch/clear, waits out the clear, kicks matrix_gen,
// releases vertex_fetch and detects drain. Statistic counters exist only with FRAME_SEQ_STATS_EN.
module frame_sequencer #(
    parameter int FRAME_CYCLES = 2_000_000,
    parameter int MIN_WAIT     = 100,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   enable_in,
    input  logic                   fb_ready_in,
    input  logic                   matrix_valid_in,
    input  logic                   fetch_done_in,
    input  logic                   pipe_idle_in,
    input  logic                   pixel_valid_in,
    output logic                   matrix_start_out,
    output logic                   fetch_rst_out,
    output logic                   fb_switch_out,
    output logic                   fb_clear_out,
    output logic                   frame_done_out,
    output logic [2:0]             state_out,
    output logic [COUNT_WIDTH-1:0] frame_count_out,
    output logic [COUNT_WIDTH-1:0] pixel_count_out,
    output logic [COUNT_WIDTH-1:0] overrun_count_out
);

    localparam int TW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int GW = $clog2(MIN_WAIT + 2);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ARM        = 3'd1,
        WAIT_CLEAR = 3'd2,
        MATRIX     = 3'd3,
        RENDER     = 3'd4,
        DONE       = 3'd5
    } state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] timer;
    logic [GW-1:0] guard;
    logic          tick, guard_done, guard_clr, drain;
    logic          frst_nxt, mstart_nxt, done_nxt;
    logic          abort, complete, pix_clr;

    assign tick       = (timer == TW'(FRAME_CYCLES - 1));
    assign guard_done = (guard == GW'(MIN_WAIT));
    assign drain      = fetch_done_in & pipe_idle_in;
    assign state_out  = state;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            timer            <= '0;
            state            <= IDLE;
            guard            <= '0;
            fetch_rst_out    <= 1'b1;
            matrix_start_out <= 1'b0;
            fb_switch_out    <= 1'b0;
            fb_clear_out     <= 1'b0;
            frame_done_out   <= 1'b0;
        end else begin
            timer            <= tick ? '0 : timer + 1'b1;
            state            <= state_nxt;
            fetch_rst_out    <= frst_nxt;
            matrix_start_out <= mstart_nxt;
            fb_switch_out    <= tick;
            fb_clear_out     <= tick;
            frame_done_out   <= done_nxt;
            if (guard_clr)
                guard <= '0;
            else if (state == WAIT_CLEAR && !guard_done)
                guard <= guard + 1'b1;
        end
    end

    always_comb begin
        state_nxt  = state;
        frst_nxt   = fetch_rst_out;
        mstart_nxt = 1'b0;
        done_nxt   = 1'b0;
        guard_clr  = 1'b0;
        abort      = 1'b0;
        complete   = 1'b0;
        pix_clr    = 1'b0;
        case (state)
            IDLE: begin
                frst_nxt = 1'b1;
                if (enable_in) state_nxt = ARM;
            end
            ARM: if (tick) begin
                state_nxt = WAIT_CLEAR;
                guard_clr = 1'b1;
            end
            WAIT_CLEAR: begin
                if (tick) abort = 1'b1;
                else if (guard_done && fb_ready_in) begin
                    state_nxt  = MATRIX;
                    mstart_nxt = 1'b1;
                end
            end
            MATRIX: begin
                if (tick) abort = 1'b1;
                else if (matrix_valid_in) begin
                    state_nxt = RENDER;
                    frst_nxt  = 1'b0;
                    pix_clr   = 1'b1;
                end
            end
            RENDER: begin
                // Drain beats a coincident tick; the tick then starts the next frame directly.
                if (drain) begin
                    complete = 1'b1;
                    done_nxt = 1'b1;
                    frst_nxt = 1'b1;
                    if (tick) begin
                        state_nxt = WAIT_CLEAR;
                        guard_clr = 1'b1;
                    end else begin
                        state_nxt = DONE;
                    end
                end else if (tick) begin
                    abort = 1'b1;
                end
            end
            DONE: if (tick) begin
                if (enable_in) begin
                    state_nxt = WAIT_CLEAR;
                    guard_clr = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = WAIT_CLEAR;
            guard_clr = 1'b1;
            frst_nxt  = 1'b1;
        end
    end

`ifdef FRAME_SEQ_STATS_EN
    logic [COUNT_WIDTH-1:0] pix_cnt, pix_nxt;

    // pix_nxt includes a strobe on the completing edge so the latched count sees it
    always_comb begin
        pix_nxt = pix_cnt;
        if (state == RENDER && pixel_valid_in && !(&pix_cnt))
            pix_nxt = pix_cnt + 1'b1;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pix_cnt           <= '0;
            frame_count_out   <= '0;
            pixel_count_out   <= '0;
            overrun_count_out <= '0;
        end else begin
            pix_cnt <= pix_clr ? '0 : pix_nxt;
            if (complete) begin
                frame_count_out <= frame_count_out + 1'b1;
                pixel_count_out <= pix_nxt;
            end
            if (abort && !(&overrun_count_out))
                overrun_count_out <= overrun_count_out + 1'b1;
        end
    end
`else
    logic unused_stats;
    assign unused_stats      = ^{pixel_valid_in, pix_clr, complete, abort};
    assign frame_count_out   = '0;
    assign pixel_count_out   = '0;
    assign overrun_count_out = '0;
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: frame_done events checked from a scoreboard queue,
// switch/clear pulses against the frame period, state/controls checked at fixed cycles.
module tb_frame_sequencer;

    localparam int FC = 1000;
    localparam int MW = 4;
    localparam int CW = 16;
`ifdef FRAME_SEQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n, enable, fb_ready, matrix_valid, fetch_done, pipe_idle, pixel_valid;
    logic matrix_start, fetch_rst, fb_switch, fb_clear, frame_done;
    logic [2:0]    state;
    logic [CW-1:0] frame_count, pixel_count, overrun_count;

    frame_sequencer #(.FRAME_CYCLES(FC), .MIN_WAIT(MW), .COUNT_WIDTH(CW)) dut (
        .clk_in            (clk),
        .rst_n_in          (rst_n),
        .enable_in         (enable),
        .fb_ready_in       (fb_ready),
        .matrix_valid_in   (matrix_valid),
        .fetch_done_in     (fetch_done),
        .pipe_idle_in      (pipe_idle),
        .pixel_valid_in    (pixel_valid),
        .matrix_start_out  (matrix_start),
        .fetch_rst_out     (fetch_rst),
        .fb_switch_out     (fb_switch),
        .fb_clear_out      (fb_clear),
        .frame_done_out    (frame_done),
        .state_out         (state),
        .frame_count_out   (frame_count),
        .pixel_count_out   (pixel_count),
        .overrun_count_out (overrun_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int fc;
        int pc;
        int oc;
        int st;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc;

    // rising edges since reset release; the frame timer must match this modulo FC
    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    function automatic int sc(input int v);
        return STATS ? v : 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic to_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic push(input int fc, input int pc, input int oc, input int st);
        exp_t e;
        e.fc = sc(fc); e.pc = sc(pc); e.oc = sc(oc); e.st = st;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_done) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_frame_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("done_frame_count", int'(frame_count), e.fc);
                    chk("done_pixel_count", int'(pixel_count), e.pc);
                    chk("done_overrun_count", int'(overrun_count), e.oc);
                    chk("done_state", int'(state), e.st);
                end
            end
            if (fb_switch || (cyc != 0 && cyc % FC == 0)) begin
                chk("fb_switch", int'(fb_switch), int'(cyc != 0 && cyc % FC == 0));
                chk("fb_clear", int'(fb_clear), int'(cyc != 0 && cyc % FC == 0));
            end
        end
    end

    initial begin
        #(200_000 * 10);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; fb_ready = 1'b1; matrix_valid = 1'b0;
        fetch_done = 1'b0; pipe_idle = 1'b0; pixel_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_fetch_rst", int'(fetch_rst), 1);
        chk("rst_state", int'(state), 0);
        chk("rst_matrix_start", int'(matrix_start), 0);
        chk("rst_switch", int'(fb_switch), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_counts", int'(frame_count | pixel_count | overrun_count), 0);
        rst_n = 1'b1;

        // frame 1: normal frame, 37 pixels, last strobe on the drain edge
        to_cyc(10);   enable = 1'b1;
        to_cyc(11);   chk("arm_state", int'(state), 1);
        to_cyc(999);  chk("arm_wait", int'(state), 1);
        to_cyc(1000); chk("wc_enter", int'(state), 2);
        to_cyc(1002); fb_ready = 1'b0; pixel_valid = 1'b1;
        to_cyc(1010); pixel_valid = 1'b0; matrix_valid = 1'b1;
        to_cyc(1011); matrix_valid = 1'b0;
        chk("mv_ignored_state", int'(state), 2);
        chk("mv_ignored_mstart", int'(matrix_start), 0);
        to_cyc(1022); fb_ready = 1'b1;
        to_cyc(1023);
        chk("mstart_pulse", int'(matrix_start), 1);
        chk("matrix_state", int'(state), 3);
        to_cyc(1024);
        chk("mstart_single", int'(matrix_start), 0);
        chk("fetch_rst_held", int'(fetch_rst), 1);
        to_cyc(1030); matrix_valid = 1'b1;
        to_cyc(1031); matrix_valid = 1'b0;
        chk("fetch_released", int'(fetch_rst), 0);
        chk("render_state", int'(state), 4);
        push(1, 37, 0, 5);
        for (int i = 0; i < 37; i++) begin
            pixel_valid = 1'b1;
            if (i == 36) begin fetch_done = 1'b1; pipe_idle = 1'b1; end
            @(negedge clk);
            pixel_valid = 1'b0; fetch_done = 1'b0; pipe_idle = 1'b0;
            @(negedge clk);
        end
        chk("done_pulse_single", int'(frame_done), 0);
        chk("done_state_hold", int'(state), 5);
        chk("done_fetch_rst", int'(fetch_rst), 1);

        // frame 2: fb_ready held low across the tick -> overrun, then retry succeeds
        to_cyc(1500); fb_ready = 1'b0;
        to_cyc(2000); chk("f2_wc", int'(state), 2);
        to_cyc(2999); chk("pre_overrun", int'(overrun_count), sc(0));
        to_cyc(3000);
        chk("overrun_count", int'(overrun_count), sc(1));
        chk("overrun_state", int'(state), 2);
        chk("overrun_fetch_rst", int'(fetch_rst), 1);
        to_cyc(3010); fb_ready = 1'b1;
        to_cyc(3011); chk("retry_matrix", int'(state), 3);
        to_cyc(3020); matrix_valid = 1'b1;
        to_cyc(3021); matrix_valid = 1'b0; chk("retry_render", int'(state), 4);
        for (int i = 0; i < 5; i++) begin
            pixel_valid = 1'b1; @(negedge clk);
            pixel_valid = 1'b0; @(negedge clk);
        end
        fetch_done = 1'b1; @(negedge clk);
        chk("no_drain_without_idle", int'(state), 4);
        push(2, 5, 1, 5);
        pipe_idle = 1'b1; @(negedge clk);
        fetch_done = 1'b0; pipe_idle = 1'b0;
        chk("retry_done", int'(state), 5);

        // frame 3: drain lands on the tick cycle
        to_cyc(4000); chk("f3_wc", int'(state), 2);
        to_cyc(4005);
        chk("f3_matrix", int'(state), 3);
        chk("f3_mstart", int'(matrix_start), 1);
        to_cyc(4010); matrix_valid = 1'b1;
        to_cyc(4011); matrix_valid = 1'b0; chk("f3_render", int'(state), 4);
        for (int i = 0; i < 3; i++) begin
            pixel_valid = 1'b1; @(negedge clk);
            pixel_valid = 1'b0; @(negedge clk);
        end
        to_cyc(4999);
        push(3, 4, 1, 2);
        fetch_done = 1'b1; pipe_idle = 1'b1; pixel_valid = 1'b1;
        to_cyc(5000);
        fetch_done = 1'b0; pipe_idle = 1'b0; pixel_valid = 1'b0;
        chk("tick_drain_state", int'(state), 2);
        chk("tick_drain_overrun", int'(overrun_count), sc(1));

        // frame 4: fb_ready high throughout is ignored until the guard expires
        to_cyc(5002); chk("guard_holds", int'(state), 2);
        to_cyc(5005); chk("f4_matrix", int'(state), 3);
        to_cyc(5010); matrix_valid = 1'b1;
        to_cyc(5011); matrix_valid = 1'b0;
        push(4, 0, 1, 5);
        to_cyc(5020); fetch_done = 1'b1; pipe_idle = 1'b1;
        to_cyc(5021); fetch_done = 1'b0; pipe_idle = 1'b0;
        chk("f4_done", int'(state), 5);
        to_cyc(5030); enable = 1'b0;
        to_cyc(5999); chk("disable_wait", int'(state), 5);
        to_cyc(6000);
        chk("disable_idle", int'(state), 0);
        chk("idle_fetch_rst", int'(fetch_rst), 1);

        // frame 5: asynchronous reset while rendering
        to_cyc(6010); enable = 1'b1;
        to_cyc(6011); chk("f5_arm", int'(state), 1);
        to_cyc(7000); chk("f5_wc", int'(state), 2);
        to_cyc(7005); chk("f5_matrix", int'(state), 3);
        to_cyc(7010); matrix_valid = 1'b1;
        to_cyc(7011); matrix_valid = 1'b0;
        chk("f5_render", int'(state), 4);
        chk("f5_fetch_rel", int'(fetch_rst), 0);
        to_cyc(7015);
        #2 rst_n = 1'b0;
        #1;
        chk("async_fetch_rst", int'(fetch_rst), 1);
        chk("async_state", int'(state), 0);
        chk("async_counts", int'(frame_count | pixel_count | overrun_count), 0);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        to_cyc(1000);
        to_cyc(1001);
        chk("post_rst_idle", int'(state), 0);

        chk("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
